// File: rtl/pipe_pkg.sv
// Shared defaults and state encoding for the pipe_seq fetch/writeback sequencer.
package pipe_pkg;

    localparam int unsigned IMW_DEF   = 4;
    localparam int unsigned DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_valid_sr.sv
// Per-stage valid tracking: one bit per in-flight instruction, shifting towards writeback.
module pipe_valid_sr
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             din,
    output logic [DEPTH-1:0] vld,
    output logic             empty
);

    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
        end else if (shift_en) begin
            vld <= {vld[DEPTH-2:0], din};
        end
    end

    // Nothing behind the writeback stage: the next shift leaves the register clear.
    assign empty = (vld[DEPTH-2:0] == '0);

endmodule

// File: rtl/pipe_seq.sv
// Fetch/writeback sequencer with IDLE/RUN/DRAIN control.
// Optional single-step fetch gating is enabled by defining PIPE_SEQ_STEP_EN.
module pipe_seq
    import pipe_pkg::*;
#(
    parameter int unsigned IMW   = IMW_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [IMW-1:0] last_pc,
    input  logic           stall,
    input  logic           halt_req,
`ifdef PIPE_SEQ_STEP_EN
    input  logic           step_mode,
    input  logic           step,
`endif
    output logic [IMW-1:0] pc_out,
    output logic           im_cs,
    output logic           rf_we_e,
    output logic           busy,
    output logic           done
);

    state_t           state_q, state_n;
    logic [IMW-1:0]   pc_q, pc_n;
    logic             cs_q, cs_n;
    logic             busy_n, done_n;
    logic             fetch_gate;
    logic             issue;
    logic             last_issue;
    logic [DEPTH-1:0] vld;
    logic             vld_empty;
    logic             unused_vld;

`ifdef PIPE_SEQ_STEP_EN
    assign fetch_gate = ~step_mode | step;
`else
    assign fetch_gate = 1'b1;
`endif

    assign im_cs      = cs_q & fetch_gate;
    assign issue      = im_cs & ~stall;
    // Saturating at all-ones also ends the run, so the PC can never wrap.
    assign last_issue = (pc_q == last_pc) | (pc_q == '1) | halt_req;
    assign rf_we_e    = vld[DEPTH-1] & ~stall;
    assign unused_vld = ^vld[DEPTH-2:0];

    pipe_valid_sr #(
        .DEPTH(DEPTH)
    ) u_valid_sr (
        .clk     (clk),
        .reset   (reset),
        .shift_en(~stall),
        .din     (issue),
        .vld     (vld),
        .empty   (vld_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            cs_q    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            cs_q    <= cs_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        cs_n    = cs_q;
        done_n  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_RUN;
                    pc_n    = '0;
                    cs_n    = 1'b1;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    if (last_issue) begin
                        state_n = ST_DRAIN;
                        cs_n    = 1'b0;
                    end else begin
                        pc_n = pc_q + IMW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (!stall && vld_empty) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cs_n    = 1'b0;
            end
        endcase
        busy_n = (state_n != ST_IDLE);
    end

    assign pc_out = pc_q;

endmodule

// File: tb/tb_pipe_seq.sv
// Directed self-checking bench for pipe_seq: cycle-by-cycle expected outputs per scenario.
module tb_pipe_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] last_pc;
    logic       stall;
    logic       halt_req;
    logic [3:0] pc_out;
    logic       im_cs;
    logic       rf_we_e;
    logic       busy;
    logic       done;
`ifdef PIPE_SEQ_STEP_EN
    logic       step_mode;
    logic       step;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_seq dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .last_pc (last_pc),
        .stall   (stall),
        .halt_req(halt_req),
`ifdef PIPE_SEQ_STEP_EN
        .step_mode(step_mode),
        .step     (step),
`endif
        .pc_out  (pc_out),
        .im_cs   (im_cs),
        .rf_we_e (rf_we_e),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One cycle: drive inputs just after the edge, then check all outputs for that cycle.
    task automatic cyc(input string nm, input logic r, input logic s, input logic stl,
                       input logic h, input logic [3:0] lp, input logic [3:0] epc,
                       input logic ecs, input logic ewe, input logic eb, input logic ed);
        @(posedge clk);
        #1;
        reset    = r;
        start    = s;
        stall    = stl;
        halt_req = h;
        last_pc  = lp;
        #1;
        check($sformatf("%s.pc", nm),   8'(pc_out),  8'(epc));
        check($sformatf("%s.cs", nm),   8'(im_cs),   8'(ecs));
        check($sformatf("%s.we", nm),   8'(rf_we_e), 8'(ewe));
        check($sformatf("%s.busy", nm), 8'(busy),    8'(eb));
        check($sformatf("%s.done", nm), 8'(done),    8'(ed));
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        stall    = 1'b0;
        halt_req = 1'b0;
        last_pc  = 4'd0;
`ifdef PIPE_SEQ_STEP_EN
        step_mode = 1'b0;
        step      = 1'b0;
`endif
        //      name     r  s  st h  lp  pc  cs we b  d
        cyc("rst0",  1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        cyc("rst1",  1, 0, 0, 0, 0,  0, 0, 0, 0, 0);

        // Scenario 1: last_pc=3, no stalls
        cyc("s1c0",  0, 1, 0, 0, 3,  0, 0, 0, 0, 0);
        cyc("s1c1",  0, 0, 0, 0, 3,  0, 1, 0, 1, 0);
        cyc("s1c2",  0, 0, 0, 0, 3,  1, 1, 0, 1, 0);
        cyc("s1c3",  0, 0, 0, 0, 3,  2, 1, 0, 1, 0);
        cyc("s1c4",  0, 0, 0, 0, 3,  3, 1, 0, 1, 0);
        cyc("s1c5",  0, 0, 0, 0, 3,  3, 0, 1, 1, 0);
        cyc("s1c6",  0, 0, 0, 0, 3,  3, 0, 1, 1, 0);
        cyc("s1c7",  0, 0, 0, 0, 3,  3, 0, 1, 1, 0);
        cyc("s1c8",  0, 0, 0, 0, 3,  3, 0, 1, 1, 0);
        cyc("s1c9",  0, 0, 0, 0, 3,  3, 0, 0, 0, 1);
        cyc("s1c10", 0, 0, 0, 0, 3,  3, 0, 0, 0, 0);

        // Scenario 2: stall in cycle 3
        cyc("s2c0",  0, 1, 0, 0, 3,  3, 0, 0, 0, 0);
        cyc("s2c1",  0, 0, 0, 0, 3,  0, 1, 0, 1, 0);
        cyc("s2c2",  0, 0, 0, 0, 3,  1, 1, 0, 1, 0);
        cyc("s2c3",  0, 0, 1, 0, 3,  2, 1, 0, 1, 0);
        cyc("s2c4",  0, 0, 0, 0, 3,  2, 1, 0, 1, 0);
        cyc("s2c5",  0, 0, 0, 0, 3,  3, 1, 0, 1, 0);
        cyc("s2c6",  0, 0, 0, 0, 3,  3, 0, 1, 1, 0);
        cyc("s2c7",  0, 0, 0, 0, 3,  3, 0, 1, 1, 0);
        cyc("s2c8",  0, 0, 0, 0, 3,  3, 0, 1, 1, 0);
        cyc("s2c9",  0, 0, 0, 0, 3,  3, 0, 1, 1, 0);
        cyc("s2c10", 0, 0, 0, 0, 3,  3, 0, 0, 0, 1);
        cyc("s2c11", 0, 0, 0, 0, 3,  3, 0, 0, 0, 0);

        // Scenario 3: single instruction
        cyc("s3c0",  0, 1, 0, 0, 0,  3, 0, 0, 0, 0);
        cyc("s3c1",  0, 0, 0, 0, 0,  0, 1, 0, 1, 0);
        cyc("s3c2",  0, 0, 0, 0, 0,  0, 0, 0, 1, 0);
        cyc("s3c3",  0, 0, 0, 0, 0,  0, 0, 0, 1, 0);
        cyc("s3c4",  0, 0, 0, 0, 0,  0, 0, 0, 1, 0);
        cyc("s3c5",  0, 0, 0, 0, 0,  0, 0, 1, 1, 0);
        cyc("s3c6",  0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
        cyc("s3c7",  0, 0, 0, 0, 0,  0, 0, 0, 0, 0);

        // Scenario 4: start with halt in IDLE, start ignored while busy, halt in cycle 3
        cyc("s4c0",  0, 1, 0, 1, 15, 0, 0, 0, 0, 0);
        cyc("s4c1",  0, 0, 0, 0, 15, 0, 1, 0, 1, 0);
        cyc("s4c2",  0, 1, 0, 0, 15, 1, 1, 0, 1, 0);
        cyc("s4c3",  0, 0, 0, 1, 15, 2, 1, 0, 1, 0);
        cyc("s4c4",  0, 0, 0, 0, 15, 2, 0, 0, 1, 0);
        cyc("s4c5",  0, 0, 0, 0, 15, 2, 0, 1, 1, 0);
        cyc("s4c6",  0, 0, 0, 0, 15, 2, 0, 1, 1, 0);
        cyc("s4c7",  0, 0, 0, 0, 15, 2, 0, 1, 1, 0);
        cyc("s4c8",  0, 0, 0, 0, 15, 2, 0, 0, 0, 1);
        cyc("s4c9",  0, 0, 0, 0, 15, 2, 0, 0, 0, 0);

        // Scenario 5: reset mid-run aborts writebacks, start under reset ignored
        cyc("s5c0",  0, 1, 0, 0, 7,  2, 0, 0, 0, 0);
        cyc("s5c1",  0, 0, 0, 0, 7,  0, 1, 0, 1, 0);
        cyc("s5c2",  0, 0, 0, 0, 7,  1, 1, 0, 1, 0);
        cyc("s5c3",  0, 0, 0, 0, 7,  2, 1, 0, 1, 0);
        cyc("s5c4",  0, 0, 0, 0, 7,  3, 1, 0, 1, 0);
        cyc("s5c5",  0, 0, 0, 0, 7,  4, 1, 1, 1, 0);
        cyc("s5c6",  1, 0, 0, 0, 7,  5, 1, 1, 1, 0);
        cyc("s5c7",  1, 1, 0, 0, 7,  0, 0, 0, 0, 0);
        cyc("s5c8",  0, 0, 0, 0, 7,  0, 0, 0, 0, 0);
        cyc("s5c9",  0, 0, 0, 0, 7,  0, 0, 0, 0, 0);
        cyc("s5c10", 0, 0, 0, 0, 7,  0, 0, 0, 0, 0);
        cyc("s5c11", 0, 0, 0, 0, 7,  0, 0, 0, 0, 0);
        cyc("s5c12", 0, 1, 0, 0, 7,  0, 0, 0, 0, 0);
        cyc("s5c13", 0, 0, 0, 0, 7,  0, 1, 0, 1, 0);
        cyc("s5c14", 0, 0, 0, 0, 7,  1, 1, 0, 1, 0);
        cyc("s5c15", 1, 0, 0, 0, 7,  2, 1, 0, 1, 0);
        cyc("s5c16", 0, 0, 0, 0, 7,  0, 0, 0, 0, 0);

`ifdef PIPE_SEQ_STEP_EN
        // Scenario 6: step mode, step every 3 cycles, last_pc=2
        step_mode = 1'b1;
        for (int c = 0; c < 14; c++) begin
            logic [3:0] epc;
            @(posedge clk);
            #1;
            start   = (c == 0);
            last_pc = 4'd2;
            step    = (c % 3 == 1);
            #1;
            epc = (c == 0 || c == 1) ? 4'd0 : (c <= 4) ? 4'd1 : 4'd2;
            check($sformatf("s6c%0d.pc", c),   8'(pc_out),  8'(epc));
            check($sformatf("s6c%0d.cs", c),   8'(im_cs),   8'(c == 1 || c == 4 || c == 7));
            check($sformatf("s6c%0d.we", c),   8'(rf_we_e), 8'(c == 5 || c == 8 || c == 11));
            check($sformatf("s6c%0d.busy", c), 8'(busy),    8'(c >= 1 && c <= 11));
            check($sformatf("s6c%0d.done", c), 8'(done),    8'(c == 12));
        end
        step_mode = 1'b0;
        step      = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
